// File: rtl/sr_display_pkg.sv
// Shared constants for the serial 7-segment display receiver: segment table,
// bad-digit code and default frame length.
package sr_display_pkg;

  localparam int unsigned NUM_DIGITS_DEF = 6;
  localparam int unsigned SEG_W          = 8;
  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned NUM_PATTERNS   = 10;

  localparam logic [DIGIT_W-1:0] DIGIT_BAD = 4'hF;

  // Segment patterns for digits 0..9, bit 0 = segment a, bit 6 = segment g.
  localparam logic [6:0] SEG_TABLE [NUM_PATTERNS] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder; the decimal point bit is ignored.
module seg_to_bcd
  import sr_display_pkg::*;
(
  input  logic [SEG_W-1:0]   seg,
  output logic [DIGIT_W-1:0] digit_c,
  output logic               match_c
);

  logic unused_dp;
  assign unused_dp = seg[SEG_W-1];

  always_comb begin
    digit_c = DIGIT_BAD;
    match_c = 1'b0;
    for (int i = 0; i < int'(NUM_PATTERNS); i++) begin
      if (seg[6:0] == SEG_TABLE[i]) begin
        digit_c = DIGIT_W'(i);
        match_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_display_rx.sv
// Receiver for a shift-register driven 7-segment display: synchronizes the serial
// bus, assembles latched bytes into digits and publishes complete time frames.
module sr_display_rx
  import sr_display_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 1024,
  parameter int unsigned NUM_DIGITS  = NUM_DIGITS_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_sclk,
  input  logic                    i_sdata,
  input  logic                    i_slatch,
  output logic [SEG_W-1:0]        o_seg,
  output logic [DIGIT_W-1:0]      o_digit,
  output logic [2:0]              o_idx,
  output logic                    o_valid,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic                    o_frame,
  output logic                    o_err
);

  localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [2:0]        LAST_SLOT = 3'(NUM_DIGITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYCLES);

  logic [1:0]         sclk_sync, sdata_sync, slatch_sync;
  logic               sclk_prev, slatch_prev;
  logic               sclk_rise_c, slatch_rise_c;
  logic               sclk_ev_q, latch_ev_q, sdata_q;
  logic [SEG_W-1:0]   sr, sr_nxt;
  logic [3:0]         bit_cnt, cnt_nxt;
  logic [2:0]         slot;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [BCD_W-1:0]   stage, stage_nxt;
  logic               commit_c, bad_cnt_c, idle_hit_c, last_slot_c;
  logic [DIGIT_W-1:0] dec_digit;
  logic               dec_match;

  assign sclk_rise_c   = sclk_sync[1] & ~sclk_prev;
  assign slatch_rise_c = slatch_sync[1] & ~slatch_prev;

  // Synchronizers plus one registered event stage; sets the fixed pin-to-valid latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync   <= '0;
      sdata_sync  <= '0;
      slatch_sync <= '0;
      sclk_prev   <= 1'b0;
      slatch_prev <= 1'b0;
      sclk_ev_q   <= 1'b0;
      latch_ev_q  <= 1'b0;
      sdata_q     <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[0], i_sclk};
      sdata_sync  <= {sdata_sync[0], i_sdata};
      slatch_sync <= {slatch_sync[0], i_slatch};
      sclk_prev   <= sclk_sync[1];
      slatch_prev <= slatch_sync[1];
      sclk_ev_q   <= sclk_rise_c;
      latch_ev_q  <= slatch_rise_c;
      sdata_q     <= sdata_sync[1];
    end
  end

  // A shift coinciding with a latch is applied first, so the latch sees that bit.
  always_comb begin
    sr_nxt    = sr;
    cnt_nxt   = bit_cnt;
    stage_nxt = stage;
    if (sclk_ev_q) begin
      sr_nxt = {sr[6:0], sdata_q};
      if (bit_cnt != 4'd15) cnt_nxt = bit_cnt + 4'd1;
    end
    commit_c    = latch_ev_q && (cnt_nxt == 4'd8);
    bad_cnt_c   = latch_ev_q && (cnt_nxt != 4'd8);
    idle_hit_c  = !sclk_ev_q && (idle_cnt == IDLE_LAST);
    last_slot_c = (slot == LAST_SLOT);
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (slot == 3'(i)) stage_nxt[i*4 +: 4] = dec_digit;
    end
  end

  seg_to_bcd u_seg_to_bcd (
    .seg     (sr_nxt),
    .digit_c (dec_digit),
    .match_c (dec_match)
  );

  // Byte assembly, slot tracking and idle resync.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr       <= '0;
      bit_cnt  <= '0;
      slot     <= '0;
      idle_cnt <= '0;
      stage    <= '0;
    end else begin
      sr <= sr_nxt;
      if (latch_ev_q || idle_hit_c) bit_cnt <= '0;
      else                          bit_cnt <= cnt_nxt;

      if (sclk_ev_q)                 idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IDLE_W'(1);

      if (idle_hit_c)       slot <= '0;
      else if (commit_c)    slot <= last_slot_c ? 3'd0 : slot + 3'd1;

      if (commit_c) stage <= stage_nxt;
    end
  end

  // Published outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg   <= '0;
      o_digit <= '0;
      o_idx   <= '0;
      o_valid <= 1'b0;
      o_bcd   <= '0;
      o_frame <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= commit_c;
      o_frame <= commit_c && last_slot_c;
      if (commit_c) begin
        o_seg   <= sr_nxt;
        o_digit <= dec_digit;
        o_idx   <= slot;
        if (last_slot_c) o_bcd <= stage_nxt;
      end
      if (bad_cnt_c || (commit_c && !dec_match)) o_err <= 1'b1;
    end
  end

endmodule

// File: doc/sr_display_rx.md
SR_DISPLAY_RX -- requirements
Module: sr_display_rx

Interface
REQ-001 Parameter IDLE_CYCLES, default 1024, means i_clk cycles without a serial-clock edge before the digit index resyncs to 0.
REQ-002 Parameter NUM_DIGITS, default 6, means segment bytes per frame.
REQ-003 i_clk  input  1  single system clock; all state on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_sclk  input  1  serial shift clock from the display transmitter, asynchronous to i_clk.
REQ-006 i_sdata  input  1  serial segment data, MSB first, valid at i_sclk rising edge.
REQ-007 i_slatch  input  1  latch strobe; a rising edge commits the last byte shifted.
REQ-008 o_seg  output  8  last committed segment byte.
REQ-009 o_digit  output  4  BCD value decoded from o_seg (0xF if unknown).
REQ-010 o_idx  output  3  digit slot of o_seg (0 = seconds units ... 5 = hours tens).
REQ-011 o_valid  output  1  one-cycle pulse when o_seg/o_digit/o_idx update.
REQ-012 o_bcd  output  24  full time {h10,h1,m10,m1,s10,s1}, updated once per complete frame.
REQ-013 o_frame  output  1  one-cycle pulse when o_bcd updates.
REQ-014 o_err  output  1  sticky error flag: bad bit count or unknown pattern; cleared by reset only.

Function
REQ-015 i_sclk, i_sdata, i_slatch SHALL each pass a two-flop synchronizer; edges are detected on the synchronized signals.
REQ-016 Inputs SHALL be sampled correctly when each i_sclk/i_slatch high and low phase lasts at least 3 i_clk periods.
REQ-017 On a synchronized i_sclk rising edge, shift register SHALL update {sr[6:0], sdata_sync} and bit counter SHALL increment, saturating at 15.
REQ-018 On a synchronized i_slatch rising edge with bit count == 8, o_seg SHALL load the shift register, o_digit the decoded value, o_idx the current slot, and o_valid SHALL pulse on the next i_clk cycle.
REQ-019 A latch with bit count != 8 SHALL set o_err, discard the byte, leave slot unchanged, and produce no o_valid.
REQ-020 Bit counter SHALL clear on every latch edge, whether valid or not.
REQ-021 Decode SHALL ignore bit 7 (dp) and map bits [6:0] per package table; an unmatched pattern yields o_digit = 0xF and sets o_err, but the byte is still committed.
REQ-022 After a committed byte, slot SHALL increment modulo NUM_DIGITS; the digit is stored into the o_bcd staging register at nibble slot.
REQ-023 Commit to slot NUM_DIGITS-1 SHALL copy staging into o_bcd and pulse o_frame in the same cycle as o_valid.
REQ-024 Idle counter SHALL clear on each sclk edge; on reaching IDLE_CYCLES it SHALL reset slot and bit count to 0 and hold, without touching o_bcd.
REQ-025 Simultaneous synchronized sclk and latch edges: shift first, then evaluate bit count including that bit.
REQ-026 Total latency from i_slatch pin rising to o_valid SHALL be 4 i_clk cycles, fixed.

Reset
REQ-027 While i_rst_n is low, all outputs SHALL be 0, and synchronizers, shift register, counters, slot and staging SHALL be 0.
REQ-028 Reset mid-byte or mid-frame SHALL discard partial data; first latch after release targets slot 0.

Structure
REQ-029 Package sr_display_pkg SHALL hold the 7-segment table (0:0x3F 1:0x06 2:0x5B 3:0x4F 4:0x66 5:0x6D 6:0x7D 7:0x07 8:0x7F 9:0x6F), DIGIT_BAD = 4'hF, and the default NUM_DIGITS.
REQ-030 Sub-module seg_to_bcd (combinational 8-bit pattern to 4-bit BCD plus match flag) SHALL be instantiated once.

Verification
REQ-031 Shift 0x06, latch -> o_seg=0x06, o_digit=1, o_idx=0, one o_valid pulse 4 cycles after latch.
REQ-032 Six bytes 0x3F,0x6D,0x4F,0x5B,0x66,0x06 (digits 0,5,3,2,4,1) -> o_bcd=0x142350, o_frame once, o_idx wraps to 0.
REQ-033 Seven bits then latch -> o_err=1, no o_valid, next 8-bit byte lands in same slot.
REQ-034 Byte 0x49 -> o_digit=0xF, o_err=1, slot advances.
REQ-035 Two digits, then 1100 idle cycles, then full frame -> o_bcd reflects the new frame only, slot starts at 0.
REQ-036 Assert i_rst_n low after 4 bits -> all outputs 0 immediately; clean byte after release decodes at slot 0.
